// File: rtl/i2cs.sv
// I2C target with a fixed 7-bit address and a byte-addressed register port.
// SCL/SDA are oversampled on clk through a synchronizer and a glitch filter.
module i2cs #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned FILT_LEN   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i2c_scl_i,
  input  logic       i2c_sda_i,
  output logic       i2c_sda_o,
  output logic       i2c_sda_oe,
  output logic       reg_wr,
  output logic       reg_rd,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  localparam int unsigned CW = 4;
  localparam int unsigned BW = 4;
  localparam logic [CW-1:0] FILT_MAX = CW'(FILT_LEN - 1);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK} state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync1, sync2, filt, filt_d;
  logic [CW-1:0]   fcnt [2];
  logic [7:0]      shift_q, shift_d, ptr_q, ptr_d, reg_addr_d, reg_wdata_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            rw_q, rw_d, first_q, first_d, ack_q, ack_d, drv_q, drv_d;
  logic            inc_q, inc_d, rd_pend_q;
  logic            sda_oe_d, busy_d, reg_wr_d, reg_rd_d;
  logic            scl_rise_c, scl_fall_c, start_c, stop_c, sda_c, addr_match_c;

  assign i2c_sda_o = 1'b0;

  // 2-FF synchronizer plus run-length filter; bit 1 is SCL, bit 0 is SDA
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '1;
      sync2  <= '1;
      filt   <= '1;
      filt_d <= '1;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      sync1  <= {i2c_scl_i, i2c_sda_i};
      sync2  <= sync1;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FILT_MAX) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + CW'(1);
        end
      end
    end
  end

  assign sda_c        = filt[0];
  assign scl_rise_c   = filt[1] & ~filt_d[1];
  assign scl_fall_c   = ~filt[1] & filt_d[1];
  assign start_c      = filt[1] & filt_d[1] & filt_d[0] & ~filt[0];
  assign stop_c       = filt[1] & filt_d[1] & ~filt_d[0] & filt[0];
  assign addr_match_c = (shift_q[7:1] == SLAVE_ADDR) && (shift_q[7:1] != 7'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop_c) begin
      state_d = IDLE;
    end else if (start_c) begin
      state_d = ADDR;
    end else if (scl_fall_c) begin
      unique case (state_q)
        ADDR:     if (bit_cnt_q == BW'(8)) state_d = addr_match_c ? ADDR_ACK : IDLE;
        ADDR_ACK: state_d = rw_q ? RD_BYTE : WR_BYTE;
        WR_BYTE:  if (bit_cnt_q == BW'(8)) state_d = WR_ACK;
        WR_ACK:   state_d = WR_BYTE;
        RD_BYTE:  if (bit_cnt_q == BW'(7)) state_d = RD_ACK;
        RD_ACK:   state_d = ack_q ? IDLE : RD_BYTE;
        default:  state_d = state_q;
      endcase
    end
  end

  // Datapath and registered-output next values
  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    rw_d        = rw_q;
    first_d     = first_q;
    ack_d       = ack_q;
    drv_d       = drv_q;
    inc_d       = 1'b0;
    ptr_d       = inc_q ? ptr_q + 8'd1 : ptr_q;
    sda_oe_d    = i2c_sda_oe;
    busy_d      = busy;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    reg_addr_d  = reg_addr;
    reg_wdata_d = reg_wdata;
    if (stop_c) begin
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      drv_d    = 1'b0;
    end else if (start_c) begin
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      drv_d     = 1'b0;
    end else begin
      unique case (state_q)
        ADDR, WR_BYTE: begin
          if (scl_rise_c) begin
            shift_d   = {shift_q[6:0], sda_c};
            bit_cnt_d = bit_cnt_q + BW'(1);
          end else if (scl_fall_c && bit_cnt_q == BW'(8)) begin
            if (state_q == ADDR) begin
              rw_d = shift_q[0];
              if (addr_match_c) begin
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
              end
            end else begin
              sda_oe_d = 1'b1;
              if (first_q) begin
                ptr_d   = shift_q;
                first_d = 1'b0;
              end else begin
                reg_wr_d    = 1'b1;
                reg_addr_d  = ptr_q;
                reg_wdata_d = shift_q;
                inc_d       = 1'b1;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall_c) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            if (rw_q) begin
              reg_rd_d   = 1'b1;
              reg_addr_d = ptr_q;
              drv_d      = 1'b0;
            end else begin
              first_d = 1'b1;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall_c) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
          end
        end
        RD_BYTE: begin
          if (scl_fall_c) begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + BW'(1);
            if (bit_cnt_q == BW'(7)) begin
              sda_oe_d = 1'b0;
              drv_d    = 1'b0;
            end else begin
              sda_oe_d = ~shift_q[6];
            end
          end else if (rd_pend_q) begin
            shift_d = reg_rdata;
            ptr_d   = ptr_q + 8'd1;
            drv_d   = 1'b1;
          end else if (drv_q) begin
            sda_oe_d = ~shift_q[7];
          end
        end
        RD_ACK: begin
          if (scl_rise_c) begin
            ack_d = sda_c;
          end else if (scl_fall_c) begin
            if (!ack_q) begin
              reg_rd_d   = 1'b1;
              reg_addr_d = ptr_q;
              bit_cnt_d  = '0;
            end else begin
              busy_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      rw_q       <= 1'b0;
      first_q    <= 1'b0;
      ack_q      <= 1'b1;
      drv_q      <= 1'b0;
      inc_q      <= 1'b0;
      rd_pend_q  <= 1'b0;
      ptr_q      <= '0;
      i2c_sda_oe <= 1'b0;
      busy       <= 1'b0;
      reg_wr     <= 1'b0;
      reg_rd     <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
    end else begin
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      rw_q       <= rw_d;
      first_q    <= first_d;
      ack_q      <= ack_d;
      drv_q      <= drv_d;
      inc_q      <= inc_d;
      rd_pend_q  <= reg_rd;
      ptr_q      <= ptr_d;
      i2c_sda_oe <= sda_oe_d;
      busy       <= busy_d;
      reg_wr     <= reg_wr_d;
      reg_rd     <= reg_rd_d;
      reg_addr   <= reg_addr_d;
      reg_wdata  <= reg_wdata_d;
    end
  end

endmodule

// File: tb/tb_i2cs.sv
// Bench for i2cs: bit-banged I2C initiator, register-port scoreboard and rdata model.
module tb_i2cs;

  localparam int unsigned T = 20;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_o, sda_oe, reg_wr, reg_rd, busy;
  logic [7:0] reg_addr, reg_wdata;
  logic [7:0] rdata = 8'h00;
  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  int         rd_count = 0;
  logic       oe_seen = 1'b0;

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~sda_oe;

  i2cs #(.SLAVE_ADDR(7'h50), .FILT_LEN(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i2c_scl_i  (scl),
    .i2c_sda_i  (sda_bus),
    .i2c_sda_o  (sda_o),
    .i2c_sda_oe (sda_oe),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (rdata),
    .busy       (busy)
  );

  // Register model: read data is addr ^ 0xFF, registered on the strobe
  always @(posedge clk) if (reg_rd) rdata <= reg_addr ^ 8'hFF;

  // Strobe monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (sda_oe) oe_seen = 1'b1;
      if (reg_wr || reg_rd) begin
        exp_t e;
        exp_t got;
        if (reg_rd) rd_count++;
        got = '{wr: reg_wr, addr: reg_addr, data: (reg_wr ? reg_wdata : 8'h00)};
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL strobe_unexpected: got wr=%0b rd=%0b addr=%h data=%h, required no strobe",
                   reg_wr, reg_rd, reg_addr, reg_wdata);
        end else begin
          e = sb.pop_front();
          if (got !== e || (reg_wr && reg_rd)) begin
            failures++;
            $display("FAIL strobe: got wr=%0b rd=%0b addr=%h data=%h, required wr=%0b addr=%h data=%h",
                     reg_wr, reg_rd, reg_addr, got.data, e.wr, e.addr, e.data);
          end
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(T);
    scl   = 1'b1; wait_clk(T);
    sda_m = 1'b0; wait_clk(T);
    scl   = 1'b0; wait_clk(T);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(T);
    scl   = 1'b1; wait_clk(T);
    sda_m = 1'b1; wait_clk(T);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_clk(T);
    scl   = 1'b1; wait_clk(T);
    scl   = 1'b0; wait_clk(T);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_clk(T);
    scl   = 1'b1; wait_clk(T / 2);
    b     = sda_bus;
    wait_clk(T / 2);
    scl   = 1'b0; wait_clk(T);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  // Bit with a 2-cycle SCL pulse in the low phase and a 2-cycle SDA pulse in the high phase
  task automatic write_bit_glitch(input logic b);
    sda_m = b;    wait_clk(T / 2);
    scl   = 1'b1; wait_clk(2);
    scl   = 1'b0; wait_clk(T / 2);
    scl   = 1'b1; wait_clk(T / 2);
    sda_m = ~b;   wait_clk(2);
    sda_m = b;    wait_clk(T / 2);
    scl   = 1'b0; wait_clk(T);
  endtask

  task automatic test_reset();
    wait_clk(3);
    checks++; if (sda_oe !== 1'b0)    begin failures++; $display("FAIL reset_sda_oe: got %b, required 0", sda_oe); end
    checks++; if (sda_o !== 1'b0)     begin failures++; $display("FAIL reset_sda_o: got %b, required 0", sda_o); end
    checks++; if (reg_wr !== 1'b0)    begin failures++; $display("FAIL reset_reg_wr: got %b, required 0", reg_wr); end
    checks++; if (reg_rd !== 1'b0)    begin failures++; $display("FAIL reset_reg_rd: got %b, required 0", reg_rd); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (reg_addr !== 8'h00) begin failures++; $display("FAIL reset_reg_addr: got %h, required 00", reg_addr); end
    checks++; if (reg_wdata !== 8'h00) begin failures++; $display("FAIL reset_reg_wdata: got %h, required 00", reg_wdata); end
    rst_n = 1'b1;
    wait_clk(10);
  endtask

  task automatic test_write();
    logic [7:0] bytes [4];
    logic ack;
    bytes[0] = 8'hA0; bytes[1] = 8'h10; bytes[2] = 8'h55; bytes[3] = 8'hAA;
    sb.push_back('{wr: 1'b1, addr: 8'h10, data: 8'h55});
    sb.push_back('{wr: 1'b1, addr: 8'h11, data: 8'hAA});
    i2c_start();
    for (int i = 0; i < 4; i++) begin
      write_byte(bytes[i], ack);
      checks++;
      if (ack !== 1'b0) begin failures++; $display("FAIL write_ack%0d: got %b, required 0", i, ack); end
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL write_busy: got %b, required 1", busy); end
    i2c_stop();
    wait_clk(10);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL write_busy_stop: got %b, required 0", busy); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL write_pending: got %0d strobes missing, required 0", sb.size()); end
  endtask

  task automatic test_read_rstart();
    logic ack;
    logic [7:0] d;
    rd_count = 0;
    sb.push_back('{wr: 1'b0, addr: 8'h20, data: 8'h00});
    sb.push_back('{wr: 1'b0, addr: 8'h21, data: 8'h00});
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h20, ack);
    i2c_start();
    write_byte(8'hA1, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL read_addr_ack: got %b, required 0", ack); end
    read_byte(d, 1'b0);
    checks++; if (d !== 8'hDF) begin failures++; $display("FAIL read_byte0: got %h, required DF", d); end
    read_byte(d, 1'b1);
    checks++; if (d !== 8'hDE) begin failures++; $display("FAIL read_byte1: got %h, required DE", d); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL read_busy_nack: got %b, required 0", busy); end
    i2c_stop();
    wait_clk(10);
    checks++; if (rd_count !== 2) begin failures++; $display("FAIL read_count: got %0d, required 2", rd_count); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL read_pending: got %0d strobes missing, required 0", sb.size()); end
  endtask

  task automatic test_mismatch();
    logic ack;
    oe_seen = 1'b0;
    i2c_start();
    write_byte(8'hA2, ack);
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL mismatch_ack: got %b, required 1", ack); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mismatch_busy: got %b, required 0", busy); end
    write_byte(8'h00, ack);
    i2c_stop();
    wait_clk(10);
    checks++; if (oe_seen !== 1'b0) begin failures++; $display("FAIL mismatch_oe: got %b, required 0", oe_seen); end
  endtask

  task automatic test_ptr_wrap();
    logic ack;
    sb.push_back('{wr: 1'b1, addr: 8'hFF, data: 8'h11});
    sb.push_back('{wr: 1'b1, addr: 8'h00, data: 8'h22});
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'hFF, ack);
    write_byte(8'h11, ack);
    write_byte(8'h22, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL wrap_ack: got %b, required 0", ack); end
    i2c_stop();
    wait_clk(10);
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL wrap_pending: got %0d strobes missing, required 0", sb.size()); end
  endtask

  task automatic test_glitch();
    logic ack;
    logic [7:0] d;
    oe_seen = 1'b0;
    scl = 1'b0; wait_clk(2); scl = 1'b1; wait_clk(10);
    sda_m = 1'b0; wait_clk(2); sda_m = 1'b1; wait_clk(10);
    checks++; if (busy !== 1'b0 || oe_seen !== 1'b0) begin
      failures++; $display("FAIL glitch_idle: got busy=%b oe_seen=%b, required 0 0", busy, oe_seen);
    end
    d = 8'hC3;
    sb.push_back('{wr: 1'b1, addr: 8'h40, data: 8'hC3});
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h40, ack);
    write_bit_glitch(d[7]);
    for (int i = 6; i >= 1; i--) write_bit(d[i]);
    write_bit_glitch(d[0]);
    read_bit(ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL glitch_data_ack: got %b, required 0", ack); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL glitch_busy: got %b, required 1", busy); end
    i2c_stop();
    wait_clk(10);
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL glitch_pending: got %0d strobes missing, required 0", sb.size()); end
    // A 3-cycle SDA pulse while SCL is high is a real START then STOP
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h40, ack);
    sda_m = 1'b1; wait_clk(T);
    scl   = 1'b1; wait_clk(T / 2);
    sda_m = 1'b0; wait_clk(3);
    sda_m = 1'b1; wait_clk(T);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_3cyc: got busy=%b, required 0", busy); end
    scl = 1'b0; wait_clk(T);
    i2c_stop();
    wait_clk(10);
  endtask

  task automatic test_abort();
    logic ack;
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h60, ack);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    i2c_stop();
    wait_clk(10);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b, required 0", busy); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL abort_pending: got %0d, required 0", sb.size()); end
    // Read from 0x90 returns 0x6F, so bit 7 drives SDA low
    sb.push_back('{wr: 1'b0, addr: 8'h90, data: 8'h00});
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h90, ack);
    i2c_start();
    write_byte(8'hA1, ack);
    checks++; if (sda_oe !== 1'b1) begin failures++; $display("FAIL abort_drive: got sda_oe=%b, required 1", sda_oe); end
    rst_n = 1'b0;
    #1;
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL abort_async_rst: got sda_oe=%b, required 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_rst_busy: got %b, required 0", busy); end
    wait_clk(2);
    scl = 1'b1; sda_m = 1'b1;
    wait_clk(T);
    rst_n = 1'b1;
    wait_clk(T);
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL abort_rd_pending: got %0d, required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_rstart();
    test_mismatch();
    test_ptr_wrap();
    test_glitch();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
